// File: rtl/hazard_unit.sv
// Hazard control for the five-stage pipeline: forwarding selects, stall/flush
// generation from a private E/M/W destination scoreboard, and saturating event counters.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rdD,
  input  logic             regwriteD,
  input  logic             memtoregD,
  input  logic             branchD,
  input  logic             jumpD,
  input  logic             pcsrcD,
  input  logic             clr_cnt,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [4:0] rs1E, rs2E, rdE, rdM, rdW;
  logic       regwriteE, memtoregE, regwriteM, memtoregM, regwriteW;
  logic       lwStall, branchStall, stallAny, flushAny;

  // x0 is hardwired to zero, so it never participates in a dependency.
  function automatic logic regHit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  always_comb begin
    lwStall     = memtoregE & regwriteE & (regHit(rs1D, rdE) | regHit(rs2D, rdE));
    branchStall = branchD &
                  ((regwriteE & (regHit(rs1D, rdE) | regHit(rs2D, rdE))) |
                   (memtoregM & (regHit(rs1D, rdM) | regHit(rs2D, rdM))));
    stallAny    = reset & (lwStall | branchStall);
    flushAny    = reset & (pcsrcD | jumpD) & ~stallAny;
  end

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    if (reset) begin
      if (regwriteM && regHit(rs1E, rdM))      forwardAE = 2'b10;
      else if (regwriteW && regHit(rs1E, rdW)) forwardAE = 2'b01;
      if (regwriteM && regHit(rs2E, rdM))      forwardBE = 2'b10;
      else if (regwriteW && regHit(rs2E, rdW)) forwardBE = 2'b01;
      forwardAD = regwriteM & regHit(rs1D, rdM);
      forwardBD = regwriteM & regHit(rs2D, rdM);
    end
  end

  assign stallF = stallAny;
  assign stallD = stallAny;
  assign flushE = stallAny;
  assign flushD = flushAny;

  // A stalled D instruction is re-presented next cycle, so E takes a bubble instead.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1E      <= 5'd0;
      rs2E      <= 5'd0;
      rdE       <= 5'd0;
      regwriteE <= 1'b0;
      memtoregE <= 1'b0;
      rdM       <= 5'd0;
      regwriteM <= 1'b0;
      memtoregM <= 1'b0;
      rdW       <= 5'd0;
      regwriteW <= 1'b0;
    end else begin
      if (stallAny) begin
        rs1E      <= 5'd0;
        rs2E      <= 5'd0;
        rdE       <= 5'd0;
        regwriteE <= 1'b0;
        memtoregE <= 1'b0;
      end else begin
        rs1E      <= rs1D;
        rs2E      <= rs2D;
        rdE       <= rdD;
        regwriteE <= regwriteD;
        memtoregE <= memtoregD;
      end
      rdM       <= rdE;
      regwriteM <= regwriteE;
      memtoregM <= memtoregE;
      rdW       <= rdM;
      regwriteW <= regwriteM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (clr_cnt) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stallAny && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flushAny && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a vector table replayed cycle by cycle through
// a scoreboard, plus a reset-during-stall sequence. A 2-bit-counter copy checks saturation.
module tb_hazard_unit;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       rw, mtr, br, jmp, pc, clr;
    logic [1:0] fAE, fBE;
    logic       fAD, fBD, stall, flushD;
  } vec_t;

  typedef struct {
    vec_t        v;
    int          id;
    logic [15:0] sA, fA;
    logic [1:0]  sB, fB;
  } exp_t;

  logic        clk, reset;
  logic [4:0]  rs1D, rs2D, rdD;
  logic        regwriteD, memtoregD, branchD, jumpD, pcsrcD, clr_cnt;
  logic [1:0]  fAEa, fBEa, fAEb, fBEb;
  logic        fADa, fBDa, stallFa, stallDa, flushDa, flushEa;
  logic        fADb, fBDb, stallFb, stallDb, flushDb, flushEb;
  logic [15:0] stallCntA, flushCntA;
  logic [1:0]  stallCntB, flushCntB;

  int checks = 0;
  int errors = 0;
  int modelSA = 0, modelFA = 0, modelSB = 0, modelFB = 0;
  vec_t vecs[$];
  exp_t sb[$];

  hazard_unit #(.CNT_W(16)) dutA (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .regwriteD(regwriteD), .memtoregD(memtoregD), .branchD(branchD), .jumpD(jumpD),
    .pcsrcD(pcsrcD), .clr_cnt(clr_cnt), .forwardAE(fAEa), .forwardBE(fBEa),
    .forwardAD(fADa), .forwardBD(fBDa), .stallF(stallFa), .stallD(stallDa),
    .flushD(flushDa), .flushE(flushEa), .stall_count(stallCntA), .flush_count(flushCntA)
  );

  hazard_unit #(.CNT_W(2)) dutB (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .regwriteD(regwriteD), .memtoregD(memtoregD), .branchD(branchD), .jumpD(jumpD),
    .pcsrcD(pcsrcD), .clr_cnt(clr_cnt), .forwardAE(fAEb), .forwardBE(fBEb),
    .forwardAD(fADb), .forwardBD(fBDb), .stallF(stallFb), .stallD(stallDb),
    .flushD(flushDb), .flushE(flushEb), .stall_count(stallCntB), .flush_count(flushCntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int rs1, rs2, rd, rw, mtr, br, jmp, pc, clr,
                              input int fAE, fBE, fAD, fBD, st, fl);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.rw = 1'(rw); v.mtr = 1'(mtr); v.br = 1'(br); v.jmp = 1'(jmp);
    v.pc = 1'(pc); v.clr = 1'(clr);
    v.fAE = 2'(fAE); v.fBE = 2'(fBE); v.fAD = 1'(fAD); v.fBD = 1'(fBD);
    v.stall = 1'(st); v.flushD = 1'(fl);
    return v;
  endfunction

  task automatic compareField(input string name, input int id,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    rs1D = v.rs1; rs2D = v.rs2; rdD = v.rd;
    regwriteD = v.rw; memtoregD = v.mtr; branchD = v.br;
    jumpD = v.jmp; pcsrcD = v.pc; clr_cnt = v.clr;
  endtask

  // Counters only move on posedges seen with reset released.
  task automatic applyStimulus(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    driveInputs(v);
    e.v = v; e.id = id;
    e.sA = 16'(modelSA); e.fA = 16'(modelFA);
    e.sB = 2'(modelSB);  e.fB = 2'(modelFB);
    sb.push_back(e);
    if (reset) begin
      if (v.clr) begin
        modelSA = 0; modelFA = 0; modelSB = 0; modelFB = 0;
      end else begin
        if (v.stall && modelSA < 65535) modelSA++;
        if (v.flushD && modelFA < 65535) modelFA++;
        if (v.stall && modelSB < 3) modelSB++;
        if (v.flushD && modelFB < 3) modelFB++;
      end
    end
  endtask

  task automatic checkOutput(input int dly);
    exp_t e;
    #(dly);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      compareField("forwardAE", e.id, 32'(fAEa), 32'(e.v.fAE));
      compareField("forwardBE", e.id, 32'(fBEa), 32'(e.v.fBE));
      compareField("forwardAD", e.id, 32'(fADa), 32'(e.v.fAD));
      compareField("forwardBD", e.id, 32'(fBDa), 32'(e.v.fBD));
      compareField("stallF", e.id, 32'(stallFa), 32'(e.v.stall));
      compareField("stallD", e.id, 32'(stallDa), 32'(e.v.stall));
      compareField("flushE", e.id, 32'(flushEa), 32'(e.v.stall));
      compareField("flushD", e.id, 32'(flushDa), 32'(e.v.flushD));
      compareField("stall_count16", e.id, 32'(stallCntA), 32'(e.sA));
      compareField("flush_count16", e.id, 32'(flushCntA), 32'(e.fA));
      compareField("stall_count2", e.id, 32'(stallCntB), 32'(e.sB));
      compareField("flush_count2", e.id, 32'(flushCntB), 32'(e.fB));
    end
  endtask

  initial begin
    vec_t nop, useV;
    exp_t e;
    nop = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);

    //                rs1 rs2 rd rw mt br jp pc cl  fAE fBE fAD fBD st fl
    vecs.push_back(nop);                                           // 0
    vecs.push_back(mk( 1, 2, 3, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 1 add r3
    vecs.push_back(mk( 3, 4, 6, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 2 reads r3
    vecs.push_back(mk( 8, 3, 9, 1, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0)); // 3
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0)); // 4
    vecs.push_back(nop);                                           // 5
    vecs.push_back(nop);                                           // 6
    vecs.push_back(mk( 1, 0, 5, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 7 lw r5
    vecs.push_back(mk( 6, 5,10, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0)); // 8 load-use
    vecs.push_back(mk( 6, 5,10, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0)); // 9 replay
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0)); // 10
    vecs.push_back(nop);                                           // 11
    vecs.push_back(nop);                                           // 12
    vecs.push_back(mk( 1, 2, 7, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 13 alu r7
    vecs.push_back(mk( 7, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0)); // 14 beq r7
    vecs.push_back(mk( 7, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0)); // 15 replay
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0)); // 16
    vecs.push_back(nop);                                           // 17
    vecs.push_back(mk( 1, 2, 0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 1)); // 18 taken
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1)); // 19 jump
    vecs.push_back(mk( 0, 0, 4, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 20 alu r4
    vecs.push_back(mk( 4, 0, 0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 1, 0)); // 21 taken, stalled
    vecs.push_back(mk( 4, 0, 0, 0, 0, 1, 0, 1, 0,  0, 0, 1, 0, 0, 1)); // 22 replay
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0)); // 23
    vecs.push_back(nop);                                           // 24
    vecs.push_back(mk( 0, 0,11, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 25 lw r11
    vecs.push_back(mk( 0,11, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0)); // 26 beq r11
    vecs.push_back(mk( 0,11, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0)); // 27 load in M
    vecs.push_back(mk( 0,11, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 28
    vecs.push_back(nop);                                           // 29
    vecs.push_back(mk( 1, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 30 write x0
    vecs.push_back(mk( 0, 0, 2, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 31 read x0
    vecs.push_back(nop);                                           // 32
    vecs.push_back(mk( 0, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 33 lw x0
    vecs.push_back(mk( 0, 0, 3, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 34
    vecs.push_back(mk( 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // 35
    vecs.push_back(nop);                                           // 36
    vecs.push_back(nop);                                           // 37
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1)); // 38 jump
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 1)); // 39 jump + clr
    vecs.push_back(nop);                                           // 40

    // Held in reset with redirect inputs active: every output must stay low.
    reset = 1'b0;
    driveInputs(mk(3, 4, 5, 1, 1, 1, 1, 1, 0, 0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    applyStimulus(mk(3, 4, 5, 1, 1, 1, 1, 1, 0, 0,0,0,0,0,0), 100);
    checkOutput(2);
    #1 driveInputs(nop);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
      checkOutput(2);
    end

    // Reset dropped while a load-use stall is active.
    applyStimulus(mk(0, 0, 5, 1, 1, 0, 0, 0, 0, 0,0,0,0,0,0), 200);
    checkOutput(2);
    useV = mk(5, 0, 6, 1, 0, 0, 0, 1, 0, 0,0,0,0,1,0);
    applyStimulus(useV, 201);
    checkOutput(2);
    #1 reset = 1'b0;
    modelSA = 0; modelFA = 0; modelSB = 0; modelFB = 0;
    e.v = nop; e.id = 202; e.sA = 16'd0; e.fA = 16'd0; e.sB = 2'd0; e.fB = 2'd0;
    sb.push_back(e);
    checkOutput(1);
    useV.stall = 1'b0;
    applyStimulus(useV, 203);
    checkOutput(2);
    #1 driveInputs(nop);
    reset = 1'b1;
    applyStimulus(nop, 204);
    checkOutput(2);
    applyStimulus(mk(5, 0, 6, 1, 0, 0, 0, 1, 0, 0,0,0,0,0,1), 205);
    checkOutput(2);
    applyStimulus(nop, 206);
    checkOutput(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
